dbg_bus_bridge: RTL and testbench
=================================

Name: dbg_bus_bridge

Overview:
- Serial-to-bus initiator: a host on the serial line issues read/write cycles on the 68k-style peripheral bus (addr, data_write/data_read, uds, lds, rw, ack).
- It drives the same bus signals that peripherals such as the uart respond to, and returns a status byte plus read data over the serial line.
- Intended as a debug/boot-load path that runs alongside the CPU, behind the bus arbiter.

Parameters:
SYS_CLK, 25_000_000, system clock frequency in Hz
BAUDRATE, 115200, serial bit rate; bit period TICK = SYS_CLK/BAUDRATE cycles (must be < 512)
BUS_TIMEOUT, 255, maximum cycles bus_cyc stays high while waiting for ack

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx  in  1  serial input, 8N1, LSB first, idle high
tx  out  1  serial output, 8N1, idle high
addr  out  24  bus byte address
data_write  out  16  write data
data_read  in  16  read data, valid in the cycle ack=1
uds  out  1  upper data strobe
lds  out  1  lower data strobe
rw  out  1  1=read, 0=write
bus_cyc  out  1  bus cycle request; addr/data/strobes are stable while high
ack  in  1  cycle complete from the responder
busy  out  1  high from the first command byte until the last response stop bit

Behaviour:
- Reset values: tx=1, bus_cyc=0, addr=0, data_write=0, uds=0, lds=0, rw=1, busy=0; FSM goes to S_CMD.
- Reset mid-frame or mid-cycle aborts immediately; nothing is transmitted.
- RX framing:
  - A falling edge starts a frame; the start bit is rechecked at TICK/2 and a high level there aborts the frame.
  - Data bits are sampled at mid-bit.
  - The stop bit must be 1, else the byte is discarded.
- Frame (host to bridge):
  - CMD byte: bit7=rw, bits1:0={uds,lds}, bits6:2 must be 0.
  - Then ADDR[23:16], ADDR[15:8], ADDR[7:0].
  - Writes then send DATA[15:8], DATA[7:0].
- Invalid CMD: bits6:2≠0 or uds=lds=0. Send status 0x45 ('E') and return to S_CMD; no bus cycle.
- FSM states: S_CMD → S_A2 → S_A1 → S_A0 → (rw=0: S_DH → S_DL) → S_BUS → S_STAT → (read OK: S_RDH → S_RDL) → S_CMD.
- Latency: S_BUS begins the cycle after the final frame byte's stop sample.
- S_BUS:
  - Outputs are registered; bus_cyc is asserted for the first cycle of S_BUS.
  - ack is honoured on any cycle where bus_cyc=1, including the first.
  - On ack: latch data_read if rw=1, drop bus_cyc the next cycle, status 0x4B ('K').
  - No ack after BUS_TIMEOUT cycles: drop bus_cyc, status 0x54 ('T'), no read data is sent.
  - ack while bus_cyc=0 is ignored.
- TX:
  - One start bit, 8 data bits LSB first, one stop bit (1), each TICK cycles.
  - Response bytes go back-to-back; the next start bit follows the previous stop bit directly.
- Bytes received in S_BUS/S_STAT/S_RDH/S_RDL are dropped; the host must wait for the response.
- busy drops in the cycle after the last stop bit; an invalid CMD holds busy through its 'E' byte.
- Address/data bytes are latched whole; addr[0] is passed through unmodified, and the responder decodes it with addr[7:1].

Optional Feature:
- Macro DBG_BUS_BRIDGE_FRAME_TIMEOUT_EN.
- When defined: an inter-byte counter runs in S_A2..S_DL.
  - If 16*TICK cycles pass with no completed byte, the partial frame is discarded, the FSM returns to S_CMD, and nothing is transmitted.
  - The counter restarts on every completed byte.
- When undefined: no counter; a partial frame waits indefinitely.

Decomposition:
- Package dbg_bus_bridge_pkg holds:
  - status codes ST_OK=8'h4B, ST_TIMEOUT=8'h54, ST_ERR=8'h45
  - CMD field bit positions
  - the FSM state enum
  - frame-timeout multiplier 16
- Sub-module uart_byte_phy holds the baud counters, the RX sampler with a byte-valid strobe, and the TX shifter with tx_start/tx_busy.
- dbg_bus_bridge keeps the frame FSM and bus handshake.

Test Plan:
- Read:
  - Stimulus: send 0x83,0x00,0x10,0x06; responder acks 3 cycles after bus_cyc with data_read=0x1234.
  - Response: bus_cyc with addr=0x001006, rw=1, uds=lds=1; tx returns 0x4B,0x12,0x34.
- Byte write:
  - Stimulus: send 0x01,0x00,0x10,0x02,0xAA,0x55; responder acks on the first bus_cyc cycle.
  - Response: addr=0x001002, rw=0, uds=0, lds=1, data_write=0xAA55, bus_cyc high exactly 1 cycle; tx returns 0x4B only.
- Timeout: read with ack never asserted → bus_cyc high exactly BUS_TIMEOUT cycles; tx returns 0x54 only.
- Invalid CMD: send 0x84 → tx returns 0x45, bus_cyc never asserts; a following valid read completes normally.
- Glitch and reset:
  - A 0.3*TICK low pulse on rx → no byte is accepted.
  - reset asserted mid-S_BUS → bus_cyc=0 and tx=1 immediately; no response is sent.
- With DBG_BUS_BRIDGE_FRAME_TIMEOUT_EN: send 0x83,0x00, then idle 20*TICK, then a full read frame → only the second frame runs.

Source files
------------

// File: rtl/dbg_bus_bridge_pkg.sv
// Shared constants for the serial debug bus bridge: status codes, CMD layout, FSM states.
// Optional frame timeout is enabled by defining DBG_BUS_BRIDGE_FRAME_TIMEOUT_EN.
package dbg_bus_bridge_pkg;

    localparam logic [7:0] ST_OK      = 8'h4B;
    localparam logic [7:0] ST_TIMEOUT = 8'h54;
    localparam logic [7:0] ST_ERR     = 8'h45;

    localparam int unsigned CMD_RW_BIT  = 7;
    localparam int unsigned CMD_RSV_HI  = 6;
    localparam int unsigned CMD_RSV_LO  = 2;
    localparam int unsigned CMD_UDS_BIT = 1;
    localparam int unsigned CMD_LDS_BIT = 0;

    localparam int unsigned FRAME_TIMEOUT_MULT = 16;

    localparam int unsigned STATE_W = 4;
    localparam logic [STATE_W-1:0] S_CMD  = 4'd0;
    localparam logic [STATE_W-1:0] S_A2   = 4'd1;
    localparam logic [STATE_W-1:0] S_A1   = 4'd2;
    localparam logic [STATE_W-1:0] S_A0   = 4'd3;
    localparam logic [STATE_W-1:0] S_DH   = 4'd4;
    localparam logic [STATE_W-1:0] S_DL   = 4'd5;
    localparam logic [STATE_W-1:0] S_BUS  = 4'd6;
    localparam logic [STATE_W-1:0] S_STAT = 4'd7;
    localparam logic [STATE_W-1:0] S_RDH  = 4'd8;
    localparam logic [STATE_W-1:0] S_RDL  = 4'd9;

    // Reserved bits must be clear and at least one strobe requested.
    function automatic logic cmd_valid(input logic [7:0] cmd);
        return (cmd[CMD_RSV_HI:CMD_RSV_LO] == '0) && (cmd[CMD_UDS_BIT] || cmd[CMD_LDS_BIT]);
    endfunction

endpackage

// File: rtl/dbg_bus_bridge_uart_byte_phy.sv
// Byte-level 8N1 UART: mid-bit RX sampler with a byte strobe and a back-to-back capable TX shifter.
module uart_byte_phy #(
    parameter int unsigned TICK = 217
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       tx,
    output logic       rx_valid_c,
    output logic [7:0] rx_data_c,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_ready_c,
    output logic       tx_last_c
);
    localparam int unsigned CNT_W = $clog2(TICK);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK - 1);
    localparam logic [CNT_W-1:0] TICK_HALF = CNT_W'(TICK / 2 - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic             rx_s1, rx_s, rx_q;
    logic [1:0]       rx_st, rx_st_n;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]       rx_bit, rx_bit_n;
    logic [7:0]       rx_sh, rx_sh_n;

    logic             tx_n, tx_busy_n;
    logic [8:0]       tx_sh, tx_sh_n;
    logic [3:0]       tx_bit, tx_bit_n;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_n;

    // Receive: start recheck at half bit, then one sample per bit period.
    always_comb begin
        rx_st_n    = rx_st;
        rx_cnt_n   = rx_cnt + 1'b1;
        rx_bit_n   = rx_bit;
        rx_sh_n    = rx_sh;
        rx_valid_c = 1'b0;
        case (rx_st)
            RX_IDLE: begin
                rx_cnt_n = '0;
                if (rx_q && !rx_s) rx_st_n = RX_START;
            end
            RX_START: if (rx_cnt == TICK_HALF) begin
                rx_cnt_n = '0;
                rx_bit_n = '0;
                rx_st_n  = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt == TICK_LAST) begin
                rx_cnt_n = '0;
                rx_sh_n  = {rx_s, rx_sh[7:1]};
                rx_bit_n = rx_bit + 3'd1;
                if (rx_bit == 3'd7) rx_st_n = RX_STOP;
            end
            RX_STOP: if (rx_cnt == TICK_LAST) begin
                rx_cnt_n   = '0;
                rx_st_n    = RX_IDLE;
                rx_valid_c = rx_s;
            end
            default: rx_st_n = RX_IDLE;
        endcase
    end

    assign rx_data_c  = rx_sh;
    assign tx_last_c  = tx_busy && (tx_bit == 4'd9) && (tx_cnt == TICK_LAST);
    assign tx_ready_c = !tx_busy || tx_last_c;

    // Transmit: a new byte may be loaded in the final stop-bit cycle so frames abut.
    always_comb begin
        tx_n      = tx;
        tx_busy_n = tx_busy;
        tx_sh_n   = tx_sh;
        tx_bit_n  = tx_bit;
        tx_cnt_n  = tx_cnt;
        if (tx_start && tx_ready_c) begin
            tx_n      = 1'b0;
            tx_busy_n = 1'b1;
            tx_sh_n   = {1'b1, tx_data};
            tx_bit_n  = '0;
            tx_cnt_n  = '0;
        end else if (tx_busy) begin
            if (tx_cnt == TICK_LAST) begin
                tx_cnt_n = '0;
                if (tx_bit == 4'd9) begin
                    tx_busy_n = 1'b0;
                    tx_n      = 1'b1;
                end else begin
                    tx_n     = tx_sh[0];
                    tx_sh_n  = {1'b1, tx_sh[8:1]};
                    tx_bit_n = tx_bit + 4'd1;
                end
            end else begin
                tx_cnt_n = tx_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_q    <= 1'b1;
            rx_st   <= RX_IDLE;
            rx_cnt  <= '0;
            rx_bit  <= '0;
            rx_sh   <= '0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_sh   <= '1;
            tx_bit  <= '0;
            tx_cnt  <= '0;
        end else begin
            rx_s1   <= rx;
            rx_s    <= rx_s1;
            rx_q    <= rx_s;
            rx_st   <= rx_st_n;
            rx_cnt  <= rx_cnt_n;
            rx_bit  <= rx_bit_n;
            rx_sh   <= rx_sh_n;
            tx      <= tx_n;
            tx_busy <= tx_busy_n;
            tx_sh   <= tx_sh_n;
            tx_bit  <= tx_bit_n;
            tx_cnt  <= tx_cnt_n;
        end
    end

endmodule

// File: rtl/dbg_bus_bridge.sv
// Serial-to-bus debug initiator: decodes host frames, runs one bus cycle, returns status/read data.
// Define DBG_BUS_BRIDGE_FRAME_TIMEOUT_EN to discard partial frames after an inter-byte gap.
module dbg_bus_bridge
    import dbg_bus_bridge_pkg::*;
#(
    parameter int unsigned SYS_CLK     = 25_000_000,
    parameter int unsigned BAUDRATE    = 115200,
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        tx,
    output logic [23:0] addr,
    output logic [15:0] data_write,
    input  logic [15:0] data_read,
    output logic        uds,
    output logic        lds,
    output logic        rw,
    output logic        bus_cyc,
    input  logic        ack,
    output logic        busy
);
    localparam int unsigned TICK  = SYS_CLK / BAUDRATE;
    localparam int unsigned TMR_W = $clog2(BUS_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUS_TIMEOUT - 1);

    logic [STATE_W-1:0] state, state_n;
    logic [23:0]        addr_n;
    logic [15:0]        data_write_n, rd_data, rd_data_n;
    logic               uds_n, lds_n, rw_n, bus_cyc_n, busy_n, rd_ok, rd_ok_n;
    logic [7:0]         status, status_n;
    logic [TMR_W-1:0]   tmr, tmr_n;

    logic       rx_valid_c, tx_start_c, tx_busy, tx_ready_c, tx_last_c;
    logic [7:0] rx_data_c, tx_byte_c;

`ifdef DBG_BUS_BRIDGE_FRAME_TIMEOUT_EN
    localparam int unsigned FT_LIMIT = FRAME_TIMEOUT_MULT * TICK;
    localparam int unsigned FT_W     = $clog2(FT_LIMIT);
    localparam logic [FT_W-1:0] FT_LAST = FT_W'(FT_LIMIT - 1);
    logic [FT_W-1:0] ft_cnt, ft_cnt_n;
`endif

    uart_byte_phy #(.TICK(TICK)) u_phy (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .tx         (tx),
        .rx_valid_c (rx_valid_c),
        .rx_data_c  (rx_data_c),
        .tx_start   (tx_start_c),
        .tx_data    (tx_byte_c),
        .tx_busy    (tx_busy),
        .tx_ready_c (tx_ready_c),
        .tx_last_c  (tx_last_c)
    );

    // Frame decode, bus handshake and response sequencing.
    always_comb begin
        state_n      = state;
        addr_n       = addr;
        data_write_n = data_write;
        uds_n        = uds;
        lds_n        = lds;
        rw_n         = rw;
        bus_cyc_n    = bus_cyc;
        busy_n       = 1'b1;
        rd_data_n    = rd_data;
        rd_ok_n      = rd_ok;
        status_n     = status;
        tmr_n        = tmr;
        tx_start_c   = 1'b0;
        tx_byte_c    = status;
        case (state)
            S_CMD: begin
                // Stay busy while the last response byte is still on the wire.
                busy_n = rx_valid_c || (tx_busy && !tx_last_c);
                if (rx_valid_c) begin
                    if (cmd_valid(rx_data_c)) begin
                        rw_n    = rx_data_c[CMD_RW_BIT];
                        uds_n   = rx_data_c[CMD_UDS_BIT];
                        lds_n   = rx_data_c[CMD_LDS_BIT];
                        state_n = S_A2;
                    end else begin
                        status_n = ST_ERR;
                        rd_ok_n  = 1'b0;
                        state_n  = S_STAT;
                    end
                end
            end
            S_A2: if (rx_valid_c) begin
                addr_n[23:16] = rx_data_c;
                state_n       = S_A1;
            end
            S_A1: if (rx_valid_c) begin
                addr_n[15:8] = rx_data_c;
                state_n      = S_A0;
            end
            S_A0: if (rx_valid_c) begin
                addr_n[7:0] = rx_data_c;
                if (rw) begin
                    bus_cyc_n = 1'b1;
                    tmr_n     = '0;
                    state_n   = S_BUS;
                end else begin
                    state_n = S_DH;
                end
            end
            S_DH: if (rx_valid_c) begin
                data_write_n[15:8] = rx_data_c;
                state_n            = S_DL;
            end
            S_DL: if (rx_valid_c) begin
                data_write_n[7:0] = rx_data_c;
                bus_cyc_n         = 1'b1;
                tmr_n             = '0;
                state_n           = S_BUS;
            end
            S_BUS: begin
                if (ack && bus_cyc) begin
                    bus_cyc_n = 1'b0;
                    status_n  = ST_OK;
                    rd_ok_n   = rw;
                    if (rw) rd_data_n = data_read;
                    state_n   = S_STAT;
                end else if (tmr == TMR_LAST) begin
                    bus_cyc_n = 1'b0;
                    status_n  = ST_TIMEOUT;
                    rd_ok_n   = 1'b0;
                    state_n   = S_STAT;
                end else begin
                    tmr_n = tmr + 1'b1;
                end
            end
            S_STAT: begin
                tx_start_c = tx_ready_c;
                tx_byte_c  = status;
                if (tx_ready_c) state_n = rd_ok ? S_RDH : S_CMD;
            end
            S_RDH: begin
                tx_start_c = tx_ready_c;
                tx_byte_c  = rd_data[15:8];
                if (tx_ready_c) state_n = S_RDL;
            end
            S_RDL: begin
                tx_start_c = tx_ready_c;
                tx_byte_c  = rd_data[7:0];
                if (tx_ready_c) state_n = S_CMD;
            end
            default: state_n = S_CMD;
        endcase
`ifdef DBG_BUS_BRIDGE_FRAME_TIMEOUT_EN
        // Inter-byte watchdog, restarted by every completed byte of a partial frame.
        ft_cnt_n = '0;
        if ((state >= S_A2) && (state <= S_DL) && !rx_valid_c) begin
            if (ft_cnt == FT_LAST) state_n = S_CMD;
            else                   ft_cnt_n = ft_cnt + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_CMD;
            addr       <= '0;
            data_write <= '0;
            uds        <= 1'b0;
            lds        <= 1'b0;
            rw         <= 1'b1;
            bus_cyc    <= 1'b0;
            busy       <= 1'b0;
            rd_data    <= '0;
            rd_ok      <= 1'b0;
            status     <= ST_OK;
            tmr        <= '0;
        end else begin
            state      <= state_n;
            addr       <= addr_n;
            data_write <= data_write_n;
            uds        <= uds_n;
            lds        <= lds_n;
            rw         <= rw_n;
            bus_cyc    <= bus_cyc_n;
            busy       <= busy_n;
            rd_data    <= rd_data_n;
            rd_ok      <= rd_ok_n;
            status     <= status_n;
            tmr        <= tmr_n;
        end
    end

`ifdef DBG_BUS_BRIDGE_FRAME_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ft_cnt <= '0;
        else       ft_cnt <= ft_cnt_n;
    end
`endif

endmodule

// File: tb/tb_dbg_bus_bridge.sv
// Scoreboard bench for dbg_bus_bridge: serial host driver, tx decoder, bus responder/monitor.
module tb_dbg_bus_bridge;

    localparam int unsigned SYS_CLK     = 1_000_000;
    localparam int unsigned BAUDRATE    = 62_500;
    localparam int unsigned BUS_TIMEOUT = 40;
    localparam int TICK   = SYS_CLK / BAUDRATE;
    localparam int CLK_NS = 10;
    localparam int BIT_NS = TICK * CLK_NS;

    typedef struct {
        logic [23:0] addr;
        logic        rw;
        logic        uds;
        logic        lds;
        logic [15:0] wdata;
        int          len;
    } bus_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic        tx;
    logic [23:0] addr;
    logic [15:0] data_write;
    logic [15:0] data_read;
    logic        uds, lds, rw, bus_cyc, ack, busy;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  exp_tx[$];
    bus_exp_t    exp_bus[$];
    int          ack_delay = -1;
    logic [15:0] rd_val = '0;
    logic        mon_en = 1'b0;

    dbg_bus_bridge #(
        .SYS_CLK     (SYS_CLK),
        .BAUDRATE    (BAUDRATE),
        .BUS_TIMEOUT (BUS_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .tx         (tx),
        .addr       (addr),
        .data_write (data_write),
        .data_read  (data_read),
        .uds        (uds),
        .lds        (lds),
        .rw         (rw),
        .bus_cyc    (bus_cyc),
        .ack        (ack),
        .busy       (busy)
    );

    always #(CLK_NS / 2) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(BIT_NS);
        end
        rx = 1'b1;
        #(BIT_NS);
    endtask

    task automatic push_bus(input logic [23:0] a, input logic r, input logic u, input logic l,
                            input logic [15:0] w, input int len);
        bus_exp_t e;
        e.addr = a; e.rw = r; e.uds = u; e.lds = l; e.wdata = w; e.len = len;
        exp_bus.push_back(e);
    endtask

    task automatic wait_idle(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (!busy && exp_tx.size() == 0) done = 1'b1;
        end
        check({tag, "_idle"}, 32'(done), 32'd1);
    endtask

    // Serial response decoder and scoreboard pop.
    initial begin : tx_mon
        logic [7:0] b;
        logic       st;
        wait (mon_en);
        forever begin
            @(negedge tx);
            #(BIT_NS / 2 + 3);
            st = tx;
            for (int i = 0; i < 8; i++) begin
                #(BIT_NS);
                b[i] = tx;
            end
            #(BIT_NS);
            check("tx_start_bit", 32'(st), 32'd0);
            check("tx_stop_bit", 32'(tx), 32'd1);
            vectors++;
            assert (exp_tx.size() != 0) else begin
                miscompares++;
                $error("FAIL tx_unexpected: observed %h expected no byte", b);
            end
            if (exp_tx.size() != 0) check("tx_byte", 32'(b), 32'(exp_tx.pop_front()));
        end
    end

    // Bus responder and bus-cycle scoreboard, sampled on the falling edge.
    initial begin : bus_mon
        int       cyc_len;
        bus_exp_t e;
        cyc_len   = 0;
        ack       = 1'b0;
        data_read = '0;
        e.len     = -1;
        forever begin
            @(negedge clk);
            if (reset) begin
                cyc_len = 0;
                ack     = 1'b0;
            end else if (bus_cyc) begin
                if (cyc_len == 0) begin
                    vectors++;
                    assert (exp_bus.size() != 0) else begin
                        miscompares++;
                        $error("FAIL bus_unexpected: observed addr %h expected no cycle", addr);
                    end
                    if (exp_bus.size() != 0) begin
                        e = exp_bus.pop_front();
                        check("bus_addr", 32'(addr), 32'(e.addr));
                        check("bus_rw", 32'(rw), 32'(e.rw));
                        check("bus_uds", 32'(uds), 32'(e.uds));
                        check("bus_lds", 32'(lds), 32'(e.lds));
                        if (!e.rw) check("bus_wdata", 32'(data_write), 32'(e.wdata));
                    end
                end
                data_read = rd_val;
                ack       = (cyc_len == ack_delay);
                cyc_len++;
            end else begin
                if (cyc_len != 0 && e.len >= 0) check("bus_len", 32'(cyc_len), 32'(e.len));
                cyc_len = 0;
                ack     = 1'b0;
            end
        end
    end

    initial begin : stim
        logic seen;
        reset = 1'b1;
        rx    = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_bus_cyc", 32'(bus_cyc), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_data_write", 32'(data_write), 32'd0);
        check("rst_uds", 32'(uds), 32'd0);
        check("rst_lds", 32'(lds), 32'd0);
        check("rst_rw", 32'(rw), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (5) @(posedge clk);

        // Word read, acked 3 cycles into the bus cycle.
        ack_delay = 3;
        rd_val    = 16'h1234;
        push_bus(24'h001006, 1'b1, 1'b1, 1'b1, 16'h0000, 4);
        exp_tx.push_back(8'h4B); exp_tx.push_back(8'h12); exp_tx.push_back(8'h34);
        send_byte(8'h83); send_byte(8'h00); send_byte(8'h10); send_byte(8'h06);
        check("read_busy", 32'(busy), 32'd1);
        wait_idle("read");

        // Lower-byte write, acked on the first bus_cyc cycle.
        ack_delay = 0;
        push_bus(24'h001002, 1'b0, 1'b0, 1'b1, 16'hAA55, 1);
        exp_tx.push_back(8'h4B);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'hAA); send_byte(8'h55);
        check("write_busy", 32'(busy), 32'd1);
        wait_idle("write");

        // Read with no responder: full timeout, status only.
        ack_delay = -1;
        push_bus(24'h002000, 1'b1, 1'b1, 1'b1, 16'h0000, int'(BUS_TIMEOUT));
        exp_tx.push_back(8'h54);
        send_byte(8'h83); send_byte(8'h00); send_byte(8'h20); send_byte(8'h00);
        wait_idle("timeout");

        // Reserved CMD bit set: error status, no bus cycle, busy held.
        exp_tx.push_back(8'h45);
        send_byte(8'h84);
        check("err_busy", 32'(busy), 32'd1);
        wait_idle("err");

        // Recovery read at an odd address.
        ack_delay = 1;
        rd_val    = 16'hBEEF;
        push_bus(24'h123457, 1'b1, 1'b1, 1'b1, 16'h0000, 2);
        exp_tx.push_back(8'h4B); exp_tx.push_back(8'hBE); exp_tx.push_back(8'hEF);
        send_byte(8'h83); send_byte(8'h12); send_byte(8'h34); send_byte(8'h57);
        wait_idle("read2");

        // Short low glitch must not start a byte.
        rx = 1'b0;
        #(TICK * 3);
        rx = 1'b1;
        #(BIT_NS * 12);
        check("glitch_busy", 32'(busy), 32'd0);
        check("glitch_tx", 32'(tx), 32'd1);

        // Reset in the middle of a bus cycle.
        ack_delay = -1;
        push_bus(24'h003000, 1'b1, 1'b1, 1'b1, 16'h0000, -1);
        send_byte(8'h83); send_byte(8'h00); send_byte(8'h30); send_byte(8'h00);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = bus_cyc;
        end
        check("rst_mid_bus_seen", 32'(seen), 32'd1);
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_bus_cyc", 32'(bus_cyc), 32'd0);
        check("rst_mid_tx", 32'(tx), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #(BIT_NS * 40);
        check("rst_mid_quiet", 32'(busy), 32'd0);

        // Full-word write after reset recovery.
        ack_delay = 2;
        push_bus(24'h00ABCD, 1'b0, 1'b1, 1'b1, 16'h1357, 3);
        exp_tx.push_back(8'h4B);
        send_byte(8'h03); send_byte(8'h00); send_byte(8'hAB); send_byte(8'hCD);
        send_byte(8'h13); send_byte(8'h57);
        wait_idle("write2");

`ifdef DBG_BUS_BRIDGE_FRAME_TIMEOUT_EN
        // Abandoned partial frame is discarded; only the second frame runs.
        ack_delay = 0;
        rd_val    = 16'hCAFE;
        push_bus(24'h004000, 1'b1, 1'b1, 1'b1, 16'h0000, 1);
        exp_tx.push_back(8'h4B); exp_tx.push_back(8'hCA); exp_tx.push_back(8'hFE);
        send_byte(8'h83); send_byte(8'h00);
        #(BIT_NS * 20);
        send_byte(8'h83); send_byte(8'h00); send_byte(8'h40); send_byte(8'h00);
        wait_idle("frame_timeout");
`endif

        #(BIT_NS * 2);
        check("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
        check("bus_queue_empty", 32'(exp_bus.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
